// File: rtl/idct_pkg.sv
// Shared definitions for the IDCT output reorder block.
//   MAX_N / wAddr : largest frame length and the matching bank address width
//   wstate_t      : write-side FSM states
//   rstate_t      : read-side FSM states
//   is_legal_n    : frame length check (power of two, 8..MAX_N)
//   reorder_addr  : bank address holding output index k of an N-point frame
package idct_pkg;

  localparam int MAX_N = 2048;
  localparam int wAddr = 11;

  typedef enum logic {W_IDLE, W_FILL} wstate_t;
  typedef enum logic {R_IDLE, R_RUN}  rstate_t;

  function automatic logic is_legal_n(input logic [11:0] n);
    logic [11:0] nm1;
    nm1 = n - 12'd1;
    return (n >= 12'd8) && (n <= 12'(MAX_N)) && ((n & nm1) == 12'd0);
  endfunction

  // x[2m] = v[m], x[2m+1] = v[N-1-m]
  function automatic logic [wAddr-1:0] reorder_addr(input logic [11:0] k,
                                                   input logic [11:0] n);
    logic [11:0] half;
    logic [11:0] a;
    half = {1'b0, k[11:1]};
    a    = k[0] ? (n - 12'd1 - half) : half;
    return wAddr'(a);
  endfunction

endpackage

// File: rtl/idct_pingpong_ram.sv
// Two-bank simple dual-port RAM, one write port and one read port.
// Read data is registered (1-cycle latency) and only updates when re is high.
// Word width is wData, or 2*wData (imag alongside real) when
// IDCT_REORDER_IMAG_EN is defined.
// Ports:
//   clk                  clock
//   we, wbank, waddr     write strobe, bank select, word address
//   wdata                write word
//   re, rbank, raddr     read strobe, bank select, word address
//   rdata                registered read word
module idct_pingpong_ram
  import idct_pkg::*;
#(
  parameter int wData = 16,
`ifdef IDCT_REORDER_IMAG_EN
  localparam int W = 2 * wData
`else
  localparam int W = wData
`endif
) (
  input  logic             clk,
  input  logic             we,
  input  logic             wbank,
  input  logic [wAddr-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic             re,
  input  logic             rbank,
  input  logic [wAddr-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem [2*MAX_N];

  always_ff @(posedge clk) begin
    if (we) mem[{wbank, waddr}] <= wdata;
    if (re) rdata <= mem[{rbank, raddr}];
  end

endmodule

// File: rtl/idct_output_reorder.sv
// IDCT output reorder: captures one scaled IFFT frame v[0..N-1] into a
// ping-pong buffer and emits it as x[2m] = v[m], x[2m+1] = v[N-1-m].
// Optional imag path: define IDCT_REORDER_IMAG_EN to add sink_imag/source_imag.
// Ports:
//   clk, rst_n_sync         clock, asynchronous active-low reset
//   sink_valid/ready        input handshake (Avalon-ST style)
//   sink_sop/eop            input frame delimiters
//   sink_real, sink_overflow, fftpts_in   sample, per-sample saturation, N (on sop)
//   source_valid/ready      output handshake with backpressure
//   source_sop/eop          reordered frame delimiters
//   source_real, fftpts_out reordered sample, N of the frame being output
//   frame_overflow          on the eop beat: any sample of the frame saturated
//   frame_error             one-cycle pulse when a malformed input frame is dropped
module idct_output_reorder
  import idct_pkg::*;
#(
  parameter int wData = 16
) (
  input  logic             clk,
  input  logic             rst_n_sync,
  input  logic             sink_valid,
  output logic             sink_ready,
  input  logic             sink_sop,
  input  logic             sink_eop,
  input  logic [wData-1:0] sink_real,
`ifdef IDCT_REORDER_IMAG_EN
  input  logic [wData-1:0] sink_imag,
  output logic [wData-1:0] source_imag,
`endif
  input  logic             sink_overflow,
  input  logic [11:0]      fftpts_in,
  output logic             source_valid,
  input  logic             source_ready,
  output logic             source_sop,
  output logic             source_eop,
  output logic [wData-1:0] source_real,
  output logic [11:0]      fftpts_out,
  output logic             frame_overflow,
  output logic             frame_error
);

`ifdef IDCT_REORDER_IMAG_EN
  localparam int RAM_W = 2 * wData;
`else
  localparam int RAM_W = wData;
`endif
  // FIFO entry: {ovf, eop, sop, n[11:0], ram word}
  localparam int ENT_W = RAM_W + 15;

  // write side
  wstate_t          wstate;
  logic             wbank, wdrop, wacc, ready_en;
  logic [11:0]      wcnt, wn;
  logic [1:0]       bank_full, bank_ovf;
  logic [11:0]      bank_n [2];
  logic             sink_beat, sop_ok, w_last, we;
  logic [wAddr-1:0] waddr;
  logic [RAM_W-1:0] wdata;

  // read side
  rstate_t          rstate;
  logic             rbank, issue, rd_last, room, inflight;
  logic [11:0]      k, rn;
  logic [wAddr-1:0] raddr;
  logic [RAM_W-1:0] rdata;
  logic             m_sop, m_eop, m_ovf;
  logic [11:0]      m_n;

  // output skid FIFO
  logic [1:0]       occ;
  logic [ENT_W-1:0] ent0, ent1, push_ent;
  logic             pop;

`ifdef IDCT_REORDER_IMAG_EN
  assign wdata = {sink_imag, sink_real};
`else
  assign wdata = sink_real;
`endif

  assign sink_ready = ready_en & ~bank_full[wbank];
  assign sink_beat  = sink_valid & sink_ready;
  assign sop_ok     = is_legal_n(fftpts_in);
  assign w_last     = (wcnt == wn - 12'd1);

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    if (sink_beat) begin
      if (sink_sop) begin
        we = sop_ok;
      end else if (wstate == W_FILL && !wdrop) begin
        we    = 1'b1;
        waddr = wAddr'(wcnt);
      end
    end
  end

  // Write FSM. wdrop marks a frame that reached beat N-1 without eop; its
  // remaining beats are swallowed until eop. A sop always restarts at address 0.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      wstate      <= W_IDLE;
      wbank       <= 1'b0;
      wdrop       <= 1'b0;
      wacc        <= 1'b0;
      wcnt        <= '0;
      wn          <= '0;
      ready_en    <= 1'b0;
      bank_full   <= '0;
      bank_ovf    <= '0;
      bank_n[0]   <= '0;
      bank_n[1]   <= '0;
      frame_error <= 1'b0;
    end else begin
      ready_en    <= 1'b1;
      frame_error <= 1'b0;
      if (sink_beat) begin
        if (sink_sop) begin
          wdrop  <= 1'b0;
          wcnt   <= 12'd1;
          wn     <= fftpts_in;
          wacc   <= sink_overflow;
          wstate <= (sop_ok && !sink_eop) ? W_FILL : W_IDLE;
          if (!sop_ok || sink_eop || (wstate == W_FILL && !wdrop))
            frame_error <= 1'b1;
        end else if (wstate == W_FILL) begin
          if (wdrop) begin
            if (sink_eop) begin
              wdrop  <= 1'b0;
              wstate <= W_IDLE;
            end
          end else if (w_last && sink_eop) begin
            bank_full[wbank] <= 1'b1;
            bank_n[wbank]    <= wn;
            bank_ovf[wbank]  <= wacc | sink_overflow;
            wbank            <= ~wbank;
            wstate           <= W_IDLE;
          end else if (sink_eop) begin
            frame_error <= 1'b1;
            wstate      <= W_IDLE;
          end else if (w_last) begin
            frame_error <= 1'b1;
            wdrop       <= 1'b1;
          end else begin
            wcnt <= wcnt + 12'd1;
            wacc <= wacc | sink_overflow;
          end
        end
      end
      // read completion frees the other bank in the same cycle
      if (rd_last) bank_full[rbank] <= 1'b0;
    end
  end

  // Read issue: the pop happening this cycle already frees a FIFO slot.
  assign pop     = source_valid & source_ready;
  assign room    = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  assign rn      = bank_n[rbank];
  assign issue   = ((rstate == R_RUN) || bank_full[rbank]) && room;
  assign rd_last = issue && (k == rn - 12'd1);
  assign raddr   = reorder_addr(k, rn);

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      rstate   <= R_IDLE;
      rbank    <= 1'b0;
      k        <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        if (rd_last) begin
          k      <= '0;
          rbank  <= ~rbank;
          rstate <= R_IDLE;
        end else begin
          k      <= k + 12'd1;
          rstate <= R_RUN;
        end
      end
    end
  end

  idct_pingpong_ram #(.wData(wData)) u_ram (
    .clk   (clk),
    .we    (we),
    .wbank (wbank),
    .waddr (waddr),
    .wdata (wdata),
    .re    (issue),
    .rbank (rbank),
    .raddr (raddr),
    .rdata (rdata)
  );

  // p0 -> p1: frame tags travel alongside the RAM read
  always_ff @(posedge clk) begin
    if (issue) begin
      m_sop <= (k == 12'd0);
      m_eop <= rd_last;
      m_n   <= rn;
      m_ovf <= bank_ovf[rbank];
    end
  end

  // p1 -> p2: RAM word plus tags into the 2-entry skid FIFO; ent0 is the head
  assign push_ent = {m_ovf, m_eop, m_sop, m_n, rdata};

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      occ  <= '0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
      case (occ)
        2'd0: if (inflight) ent0 <= push_ent;
        2'd1: begin
          if (inflight && pop) ent0 <= push_ent;
          else if (inflight)   ent1 <= push_ent;
        end
        default: if (pop) ent0 <= ent1;
      endcase
    end
  end

  assign source_valid   = (occ != 2'd0);
  assign source_real    = ent0[wData-1:0];
`ifdef IDCT_REORDER_IMAG_EN
  assign source_imag    = ent0[2*wData-1:wData];
`endif
  assign fftpts_out     = ent0[RAM_W +: 12];
  assign source_sop     = source_valid & ent0[ENT_W-3];
  assign source_eop     = source_valid & ent0[ENT_W-2];
  assign frame_overflow = source_valid & ent0[ENT_W-2] & ent0[ENT_W-1];

endmodule

// File: tb/tb_idct_output_reorder.sv
module tb_idct_output_reorder;

  logic        clk = 1'b0;
  logic        rst_n_sync;
  logic        sink_valid, sink_ready, sink_sop, sink_eop, sink_overflow;
  logic [15:0] sink_real;
  logic [11:0] fftpts_in;
  logic        source_valid, source_ready, source_sop, source_eop;
  logic [15:0] source_real;
  logic [11:0] fftpts_out;
  logic        frame_overflow, frame_error;
`ifdef IDCT_REORDER_IMAG_EN
  logic [15:0] sink_imag, source_imag;
  assign sink_imag = 16'h0;
`endif

  always #5 clk = ~clk;

  idct_output_reorder dut (
    .clk            (clk),
    .rst_n_sync     (rst_n_sync),
    .sink_valid     (sink_valid),
    .sink_ready     (sink_ready),
    .sink_sop       (sink_sop),
    .sink_eop       (sink_eop),
    .sink_real      (sink_real),
`ifdef IDCT_REORDER_IMAG_EN
    .sink_imag      (sink_imag),
    .source_imag    (source_imag),
`endif
    .sink_overflow  (sink_overflow),
    .fftpts_in      (fftpts_in),
    .source_valid   (source_valid),
    .source_ready   (source_ready),
    .source_sop     (source_sop),
    .source_eop     (source_eop),
    .source_real    (source_real),
    .fftpts_out     (fftpts_out),
    .frame_overflow (frame_overflow),
    .frame_error    (frame_error)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int out_count = 0;
  int err_pulses = 0;
  int out_cycles[$];
  // {real, sop, eop, fftpts, frame_overflow}
  logic [30:0] sb[$];

  function automatic bit legal_n(input int n);
    return (n >= 8) && (n <= 2048) && ((n & (n - 1)) == 0);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // scoreboard: every accepted output beat is popped and compared
  initial begin : monitor
    logic [30:0] got, exp;
    forever begin
      @(negedge clk);
      if (frame_error === 1'b1) err_pulses++;
      if (source_valid === 1'b1 && source_ready === 1'b1) begin
        got = {source_real, source_sop, source_eop, fftpts_out, frame_overflow};
        out_cycles.push_back(cyc);
        out_count++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected got=%h expected=none", got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL out_beat got=%h expected=%h", got, exp);
          end
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  task automatic send_frame(input int n, input int base, input int eop_at,
                            input int ovf_at, input int fpts,
                            output int stalls, output int eop_cyc);
    bit acc;
    int waitc;
    int idx;
    stalls  = 0;
    eop_cyc = 0;
    for (int i = 0; i <= eop_at; i++) begin
      sink_valid    = 1'b1;
      sink_sop      = (i == 0);
      sink_eop      = (i == eop_at);
      sink_real     = 16'(base + i);
      sink_overflow = (i == ovf_at);
      fftpts_in     = 12'(fpts);
      waitc = 0;
      forever begin
        @(negedge clk);
        acc = sink_ready;
        @(posedge clk);
        #1;
        if (acc) break;
        stalls++;
        waitc++;
        if (waitc > 20000) begin
          checks++;
          errors++;
          $display("FAIL sink_stall got=ready_low expected=ready_high");
          sink_valid = 1'b0;
          return;
        end
      end
    end
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_overflow = 1'b0;
    eop_cyc = cyc;
    if (legal_n(fpts) && eop_at == n - 1) begin
      for (int kk = 0; kk < n; kk++) begin
        idx = (kk % 2 == 1) ? (n - 1 - kk / 2) : (kk / 2);
        sb.push_back({16'(base + idx), kk == 0, kk == n - 1, 12'(n),
                      (kk == n - 1) && (ovf_at >= 0) && (ovf_at < n)});
      end
    end
  endtask

  task automatic wait_empty(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n_sync = 1'b0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    sink_real = '0; sink_overflow = 1'b0; fftpts_in = '0; source_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sink_ready, source_valid, source_sop, source_eop, source_real,
         fftpts_out, frame_overflow, frame_error} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h expected=0", {sink_ready, source_valid,
               source_sop, source_eop, source_real, fftpts_out, frame_overflow, frame_error});
    end
    rst_n_sync = 1'b1;
    @(negedge clk);
    checks++;
    if (sink_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge got=%b expected=0", sink_ready);
    end
    @(negedge clk);
    checks++;
    if (sink_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_edge got=%b expected=1", sink_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int st, ec, c0, first;
    bit ok;
    out_cycles.delete();
    c0 = out_count;
    send_frame(8, 0, 7, -1, 8, st, ec);
    wait_empty(100, ok);
    checks++;
    if (!ok || out_count - c0 != 8) begin
      errors++;
      $display("FAIL basic_count got=%0d expected=8", out_count - c0);
    end
    first = (out_cycles.size() > 0) ? out_cycles[0] - ec : -1;
    checks++;
    if (first != 2) begin
      errors++;
      $display("FAIL basic_latency got=%0d expected=2", first);
    end
  endtask

  task automatic test_back_to_back;
    int st, ec, c0, span;
    bit ok;
    out_cycles.delete();
    c0 = out_count;
    send_frame(8, 0, 7, -1, 8, st, ec);
    send_frame(8, 10, 7, -1, 8, st, ec);
    wait_empty(100, ok);
    checks++;
    if (!ok || out_count - c0 != 16) begin
      errors++;
      $display("FAIL b2b_count got=%0d expected=16", out_count - c0);
    end
    span = (out_cycles.size() == 16) ? out_cycles[15] - out_cycles[0] : -1;
    checks++;
    if (span != 15) begin
      errors++;
      $display("FAIL b2b_gapless got=%0d expected=15", span);
    end
  endtask

  task automatic test_backpressure;
    int s1, s2, s3, ec, c0;
    bit ok, done;
    c0 = out_count;
    done = 1'b0;
    ok = 1'b0;
    s1 = 0; s2 = 0; s3 = 0;
    fork
      begin
        send_frame(512, 1000, 511, -1, 512, s1, ec);
        send_frame(512, 2000, 511, -1, 512, s2, ec);
        send_frame(512, 3000, 511, -1, 512, s3, ec);
        wait_empty(20000, ok);
        done = 1'b1;
      end
      begin
        while (!done) begin
          for (int j = 0; j < 4; j++) begin
            source_ready = (j == 0) || (j == 3);
            @(posedge clk);
            #1;
          end
        end
      end
    join
    source_ready = 1'b1;
    checks++;
    if (!ok || out_count - c0 != 1536) begin
      errors++;
      $display("FAIL bp_count got=%0d expected=1536", out_count - c0);
    end
    checks++;
    if (s1 != 0 || s2 != 0) begin
      errors++;
      $display("FAIL bp_early_stall got=%0d,%0d expected=0,0", s1, s2);
    end
    checks++;
    if (s3 == 0) begin
      errors++;
      $display("FAIL bp_both_full_stall got=%0d expected=nonzero", s3);
    end
  endtask

  task automatic test_frame_error;
    int st, ec, e0, c0;
    bit ok;
    c0 = out_count;
    e0 = err_pulses;
    send_frame(8, 50, 4, -1, 8, st, ec);        // eop too early
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err_pulses - e0 != 1) begin
      errors++;
      $display("FAIL err_short got=%0d expected=1", err_pulses - e0);
    end
    e0 = err_pulses;
    send_frame(12, 70, 11, -1, 12, st, ec);     // illegal N
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err_pulses - e0 != 1) begin
      errors++;
      $display("FAIL err_illegal_n got=%0d expected=1", err_pulses - e0);
    end
    e0 = err_pulses;
    send_frame(8, 80, 9, -1, 8, st, ec);        // no eop at beat N-1
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err_pulses - e0 != 1) begin
      errors++;
      $display("FAIL err_long got=%0d expected=1", err_pulses - e0);
    end
    checks++;
    if (out_count != c0) begin
      errors++;
      $display("FAIL err_no_output got=%0d expected=0", out_count - c0);
    end
    send_frame(8, 60, 7, -1, 8, st, ec);
    wait_empty(100, ok);
    checks++;
    if (!ok || out_count - c0 != 8) begin
      errors++;
      $display("FAIL err_recover got=%0d expected=8", out_count - c0);
    end
  endtask

  task automatic test_overflow;
    int st, ec, c0;
    bit ok;
    c0 = out_count;
    send_frame(8, 90, 7, 3, 8, st, ec);
    send_frame(8, 100, 7, -1, 8, st, ec);
    wait_empty(100, ok);
    checks++;
    if (!ok || out_count - c0 != 16) begin
      errors++;
      $display("FAIL ovf_count got=%0d expected=16", out_count - c0);
    end
  endtask

  task automatic test_reset_mid;
    int st, ec, c0;
    bit ok;
    c0 = out_count;
    send_frame(2048, 0, 2047, -1, 2048, st, ec);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (out_count - c0 < 10) begin
      errors++;
      $display("FAIL mid_progress got=%0d expected>=10", out_count - c0);
    end
    rst_n_sync = 1'b0;
    #1;
    checks++;
    if ({sink_ready, source_valid, source_sop, source_eop, source_real,
         fftpts_out, frame_overflow, frame_error} !== 34'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got=%h expected=0", {sink_ready, source_valid,
               source_sop, source_eop, source_real, fftpts_out, frame_overflow, frame_error});
    end
    sb.delete();
    @(posedge clk);
    #1;
    rst_n_sync = 1'b1;
    @(posedge clk);
    #1;
    c0 = out_count;
    send_frame(8, 300, 7, -1, 8, st, ec);
    wait_empty(100, ok);
    checks++;
    if (!ok || out_count - c0 != 8) begin
      errors++;
      $display("FAIL mid_after_reset got=%0d expected=8", out_count - c0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_frame_error();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idct_output_reorder.md
Name: idct_output_reorder

Overview:
- Sits directly downstream of idct_aftIFFT_scaling in the IDCT chain, after the IFFT.
- Captures one scaled IFFT frame v[0..N-1] into a ping-pong buffer and emits it in IDCT order: x[2m] = v[m], x[2m+1] = v[N-1-m].
- Input is Avalon-ST style with sop/eop; output is valid/ready with backpressure.
- Also reports a per-frame overflow flag, aggregated from the upstream per-sample overflow.

Parameters:
- wData, 16, sample width (matches upstream wDataOut)
- MAX_N, 2048, largest frame length; each buffer bank holds MAX_N words
- wAddr, 11, log2(MAX_N)

Ports:
- clk  in  1  clock
- rst_n_sync  in  1  asynchronous active-low reset
- sink_valid  in  1  input sample valid
- sink_ready  out  1  block can accept a sample
- sink_sop  in  1  first sample of frame
- sink_eop  in  1  last sample of frame
- sink_real  in  wData  scaled IFFT real part
- sink_overflow  in  1  upstream saturation flag for this sample
- fftpts_in  in  12  frame length N; sampled on the sop beat
- source_valid  out  1  output sample valid
- source_ready  in  1  downstream accepts
- source_sop  out  1  first reordered sample
- source_eop  out  1  last reordered sample
- source_real  out  wData  reordered sample
- fftpts_out  out  12  N of the frame being output
- frame_overflow  out  1  qualified with the source_eop beat: any sample of this frame saturated
- frame_error  out  1  one-cycle pulse: malformed input frame dropped

Behaviour:
- Reset (asynchronous assert, clk-synchronous release):
  - Outputs: sink_ready=0, source_valid=0, source_sop=0, source_eop=0, source_real=0, fftpts_out=0, frame_overflow=0, frame_error=0.
  - Both banks marked empty; write and read pointers cleared.
  - sink_ready rises in the first cycle after release.
- A beat transfers when valid&ready, on either side.
- Write FSM, states W_IDLE, W_FILL:
  - W_IDLE:
    - sop beat: latch N=fftpts_in, write sample to address 0, clear the frame overflow accumulator, go to W_FILL.
    - Non-sop beats are discarded silently.
  - W_FILL: each beat writes address wcnt and ORs sink_overflow into the accumulator.
  - eop on beat N-1: mark bank full, store N and the overflow flag with the bank, toggle the write bank, go to W_IDLE.
- Malformed input frames (drop frame, pulse frame_error, bank stays empty):
  - eop before N-1 → W_IDLE.
  - Beat N-1 without eop: remaining beats discarded until eop → W_IDLE.
  - sop inside W_FILL: current frame dropped, new frame restarts at address 0 in the same bank.
- Legal N: powers of two from 8 to MAX_N. Any other fftpts_in at sop drops the frame with frame_error.
- sink_ready = 1 while the write bank is empty; 0 when both banks are full.
- Read FSM, states R_IDLE, R_RUN:
  - R_IDLE → R_RUN when the read bank is full.
  - Read index k runs 0..N-1. Address = k>>1 for even k, N-1-(k>>1) for odd k.
  - After k=N-1 is issued: free the bank, toggle the read bank, go to R_IDLE. The next full bank may start the following cycle, so there is no bubble between frames.
- Output path:
  - Synchronous RAM read has 1-cycle latency, feeding a 2-entry output skid FIFO.
  - A read is issued only when FIFO occupancy plus in-flight reads < 2.
  - Full throughput at source_ready=1. Output holds stable while source_valid&!source_ready.
- Frame flags: source_sop on k=0. source_eop, fftpts_out and frame_overflow are valid on k=N-1.
- Latency: a full frame is written, then the first output appears 2 cycles after the bank-full edge.
- Simultaneous write completion and read completion on different banks: both take effect in the same cycle.

Optional Feature:
- Macro IDCT_REORDER_IMAG_EN.
- Defined:
  - Adds ports sink_imag (in, wData) and source_imag (out, wData).
  - Imag is stored in parallel banks and reordered identically.
- Undefined: imag ports absent; RAM width is wData plus nothing else.

Decomposition:
- Shared package idct_pkg:
  - Constants MAX_N and wAddr.
  - Legal-N check function.
  - Typedefs for write and read FSM states.
  - Reorder-address function.
- One sub-module idct_pingpong_ram: dual-bank simple dual-port RAM with 1-cycle read latency, width set by IDCT_REORDER_IMAG_EN.

Test Plan:
- N=8, input 0..7, source_ready=1 → output 0,7,1,6,2,5,3,4; sop on 0, eop on 4; fftpts_out=8; first output 2 cycles after input eop.
- Two back-to-back N=8 frames (0..7 then 10..17) → second output 10,17,11,16,12,15,13,14 with no idle cycle between frames.
- source_ready toggled 1,0,0,1 repeating during an N=512 ramp → order and data exact, no loss or duplication; sink_ready=0 only while both banks are full.
- N=8 with eop on the 5th beat → frame_error pulses once, no output; the following good frame outputs correctly.
- N=8 with sink_overflow=1 on beat 3 only → frame_overflow=1 on that frame's eop; the next clean frame has frame_overflow=0.
- Reset asserted mid-output of an N=2048 frame → all outputs 0 immediately; after release, a new N=8 frame outputs correctly with no stale data.
